// File: rtl/xor_link_pkg.sv
// xor_link_pkg
// Definitions shared by both ends of the XOR-parity serial link: the
// receiver state encoding, the line levels that make up a frame, and the
// parity helpers.
// Frame on the wire: START_BIT, data LSB first, parity bit, STOP_BIT.
// The line rests at IDLE_LEVEL between frames.
package xor_link_pkg;

    // Receiver frame-walk states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } link_state_e;

    // Line levels of the frame format
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Widest data word supported on the link
    localparam int MAX_DATA_W = 16;

    // One step of a running XOR parity: fold one line bit into the accumulator
    function automatic logic parity_acc(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // Parity bit for a whole word. Unused upper bits must be zero.
    // odd=0 gives the XOR of the data, odd=1 gives its inverse.
    function automatic logic parity_of(input logic [MAX_DATA_W-1:0] data,
                                       input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer that brings an asynchronous level into the clk_i
// domain. Both flops reset to RESET_VAL, so a line that idles at that level
// produces no spurious edge when reset is released.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   d_i    asynchronous input
//   q_o    synchronized output, two cycles behind d_i
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage synchronizer chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/xor_parity_rx.sv
// xor_parity_rx
// Receiver for the XOR-parity serial link. It rebuilds a data word from
// RxD and checks the parity bit and the stop bit of each frame.
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset; aborts any frame in progress
//   RxD        asynchronous serial line, idle high
//   Data       last received word; held until the next Valid
//   Valid      one-cycle pulse per completed frame, error frames included
//   ParityErr  parity status of the last frame; qualified by Valid
//   FrameErr   stop-bit status of the last frame; qualified by Valid
//   Busy       high while a frame is in progress
module xor_parity_rx
    import xor_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RxD,
    output logic [DATA_W-1:0] Data,
    output logic              Valid,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic              rx_s;
    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              rx_prev_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_out_q, perr_out_d;
    logic              ferr_q, ferr_d;
    logic              busy_q;

    sync_2ff #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (RxD),
        .q_o   (rx_s)
    );

    // Frame walk: next state, counters, shift register and result capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                // A start needs a falling edge. A line stuck low after a
                // framing error therefore has to return high first.
                if ((rx_s == START_BIT) && (rx_prev_q == IDLE_LEVEL)) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = CNT_ZERO;
                    if (rx_s == START_BIT) begin
                        state_d = ST_DATA;
                        idx_d   = IDX_ZERO;
                        par_d   = ODD_PARITY;
                    end else begin
                        // Line went high again before mid-bit: a glitch
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    for (int i = 0; i < DATA_W; i++) begin
                        shift_d[i] = (idx_q == IDX_W'(i)) ? rx_s : shift_q[i];
                    end
                    par_d = parity_acc(par_q, rx_s);
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    // The received parity bit folded into the running
                    // parity is zero on a good frame.
                    perr_d  = parity_acc(par_q, rx_s);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = CNT_ZERO;
                    data_d     = shift_q;
                    perr_out_d = perr_q;
                    ferr_d     = (rx_s != STOP_BIT);
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            idx_q      <= IDX_ZERO;
            shift_q    <= {DATA_W{1'b0}};
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            rx_prev_q  <= IDLE_LEVEL;
            data_q     <= {DATA_W{1'b0}};
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            rx_prev_q  <= rx_s;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            // Busy is registered from the current state, so it lags the
            // state by one cycle. It is therefore still high while Valid
            // pulses and falls on the cycle after Valid.
            busy_q     <= (state_q != ST_IDLE) ? 1'b1 : 1'b0;
        end
    end

    assign Data      = data_q;
    assign Valid     = valid_q;
    assign ParityErr = perr_out_q;
    assign FrameErr  = ferr_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_xor_parity_rx.sv
// tb_xor_parity_rx
// Directed bench for xor_parity_rx with CLKS_PER_BIT=4 and DATA_W=8.
// One even-parity instance and one odd-parity instance share the line.
// Expected frame results are queued as frames are driven and are checked
// when Valid appears.
module tb_xor_parity_rx;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RxD;
    logic [DW-1:0] data_e, data_o;
    logic          valid_e, pe_e, fe_e, busy_e;
    logic          valid_o, pe_o, fe_o, busy_o;

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) dut (
        .CLK(CLK), .RST(RST), .RxD(RxD), .Data(data_e), .Valid(valid_e),
        .ParityErr(pe_e), .FrameErr(fe_e), .Busy(busy_e)
    );

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1)) dut_odd (
        .CLK(CLK), .RST(RST), .RxD(RxD), .Data(data_o), .Valid(valid_o),
        .ParityErr(pe_o), .FrameErr(fe_o), .Busy(busy_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       pe_even;
        logic       pe_odd;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_mis     = 0;
    int   n_valid   = 0;
    int   cyc       = 0;
    int   vcyc_last = 0;
    int   vcyc_prev = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        exp_t e;
        e.d       = d;
        e.pe_even = p ^ (^d);
        e.pe_odd  = ~(p ^ (^d));
        e.fe      = ~stop;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            tick();
            i++;
        end
        check(tag, 16'(sb.size()), 16'd0);
    endtask

    // Monitor: pop and compare on every Valid, check Busy around it
    initial begin : mon
        exp_t e;
        logic valid_prev;
        valid_prev = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (valid_prev) check("busy_after_valid", 16'(busy_e), 16'd0);
            if (valid_e === 1'b1) begin
                n_valid++;
                vcyc_prev = vcyc_last;
                vcyc_last = cyc;
                check("busy_at_valid", 16'(busy_e), 16'd1);
                check("valid_odd", 16'(valid_o), 16'd1);
                check("busy_odd", 16'(busy_o), 16'(busy_e));
                check("valid_expected", 16'(sb.size() != 0), 16'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("data", 16'(data_e), 16'(e.d));
                    check("data_odd", 16'(data_o), 16'(e.d));
                    check("perr_even", 16'(pe_e), 16'(e.pe_even));
                    check("perr_odd", 16'(pe_o), 16'(e.pe_odd));
                    check("ferr", 16'(fe_e), 16'(e.fe));
                    check("ferr_odd", 16'(fe_o), 16'(e.fe));
                end
            end
            valid_prev = valid_e;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        int nv;
        int bcnt;
        RST = 1'b1;
        RxD = 1'b1;
        repeat (3) tick();
        check("rst_data", 16'(data_e), 16'd0);
        check("rst_valid", 16'(valid_e), 16'd0);
        check("rst_perr", 16'(pe_e), 16'd0);
        check("rst_ferr", 16'(fe_e), 16'd0);
        check("rst_busy", 16'(busy_e), 16'd0);
        RST = 1'b0;
        repeat (5) tick();

        // Good frame, then the same word with the parity bit flipped
        send_frame(8'hA5, 1'b0, 1'b1);
        RxD = 1'b1;
        drain("drain_a5_good");
        repeat (4) tick();
        send_frame(8'hA5, 1'b1, 1'b1);
        RxD = 1'b1;
        drain("drain_a5_perr");
        repeat (4) tick();

        // Stop bit low, line held low, then a clean frame
        send_frame(8'h3C, 1'b0, 1'b0);
        RxD = 1'b0;
        repeat (8) tick();
        repeat (12) begin
            tick();
            check("busy_line_low", 16'(busy_e), 16'd0);
        end
        drain("drain_3c");
        RxD = 1'b1;
        repeat (8) tick();
        send_frame(8'h01, 1'b1, 1'b1);
        RxD = 1'b1;
        drain("drain_01");
        repeat (4) tick();

        // One-cycle low glitch on the idle line
        nv = n_valid;
        RxD = 1'b0;
        tick();
        RxD = 1'b1;
        bcnt = 0;
        repeat (12) begin
            tick();
            if (busy_e === 1'b1) bcnt++;
        end
        check("glitch_busy_1to2", 16'((bcnt >= 1) && (bcnt <= 2)), 16'd1);
        check("glitch_no_valid", 16'(n_valid), 16'(nv));
        check("glitch_data_hold", 16'(data_e), 16'h01);

        // Reset after the third data bit of 0xFF
        nv = n_valid;
        RxD = 1'b0;
        repeat (CPB) tick();
        RxD = 1'b1;
        repeat (3 * CPB) tick();
        RST = 1'b1;
        tick();
        check("abort_data", 16'(data_e), 16'd0);
        check("abort_valid", 16'(valid_e), 16'd0);
        check("abort_perr", 16'(pe_e), 16'd0);
        check("abort_ferr", 16'(fe_e), 16'd0);
        check("abort_busy", 16'(busy_e), 16'd0);
        RST = 1'b0;
        repeat (60) tick();
        check("abort_no_valid", 16'(n_valid), 16'(nv));
        send_frame(8'h81, 1'b0, 1'b1);
        RxD = 1'b1;
        drain("drain_81");
        repeat (4) tick();

        // Back-to-back frames
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        RxD = 1'b1;
        drain("drain_b2b");
        repeat (4) tick();
        check("b2b_spacing", 16'(vcyc_last - vcyc_prev), 16'd44);
        check("valid_count", 16'(n_valid), 16'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
